programmable_sequence_generator: RTL and testbench
==================================================

Name: programmable_sequence_generator

Overview:
Transmit-side counterpart of programmable_sequence_detector. Holds a programmable WIDTH-bit pattern and serializes it MSB-first onto a 1-bit stream (data_o/valid_o), repeated a set number of times or continuously, with a programmable idle gap between frames. It drives detector data_i in loopback benches and acts as a pattern source for link bring-up.

Parameters:
WIDTH, 6, pattern length in bits (>=2)
REPEAT_W, 4, width of frame repeat count
GAP_W, 4, width of inter-frame gap count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
load_i  input  1  latch prog_sequence_i into pattern register (IDLE only)
prog_sequence_i  input  WIDTH  pattern to transmit, bit WIDTH-1 sent first
start_i  input  1  begin transmission (IDLE only)
repeat_i  input  REPEAT_W  frame count; 0 = continuous until stop_i
gap_i  input  GAP_W  idle cycles between frames; 0 = back-to-back
stop_i  input  1  finish current frame, then end
data_o  output  1  serial bit
valid_o  output  1  data_o carries a pattern bit this cycle
busy_o  output  1  transmission in progress
done_o  output  1  one-cycle pulse after last bit of last frame

Behaviour:
- Reset (rst low, async): pattern register, counters, all outputs = 0; state IDLE.
- All outputs registered. States: IDLE, SEND, GAP.
- IDLE: load_i=1 latches prog_sequence_i. start_i=1 latches repeat_i, gap_i, moves to SEND. load_i and start_i in same cycle: newly loaded pattern is sent.
- Latency: start_i sampled at edge k; first bit (pattern[WIDTH-1]) on data_o with valid_o=1 and busy_o=1 from edge k+1.
- SEND: one bit per cycle MSB-first, bit index counts WIDTH-1 down to 0; valid_o=1 for exactly WIDTH consecutive cycles per frame.
- After final bit of a frame: if frames remain (or continuous and no pending stop): gap_i>0 -> GAP for exactly gap_i cycles (valid_o=0, data_o=0, busy_o=1), then SEND; gap_i=0 -> next frame MSB in the very next cycle.
- Last frame ends: next cycle busy_o=0, valid_o=0, done_o=1 (one cycle), state IDLE. New start_i accepted in that same cycle.
- Frame counter: counts up to repeat_i; repeat_i=0 continuous, wrap-free (counter saturates/unused).
- stop_i: sticky request once busy; current frame completes in full, gap skipped, then done. stop_i in GAP: terminate immediately, done_o next cycle. stop_i in IDLE ignored.
- load_i, start_i, repeat_i, gap_i ignored while busy_o=1; pattern cannot change mid-stream.
- Reset mid-frame: stream aborts immediately, no done_o.

Optional Feature:
SEQ_GEN_PARITY_EN: defined -> each frame followed by one even-parity bit (XOR of pattern) with valid_o=1; frame length WIDTH+1 cycles; gap starts after parity bit. Undefined -> frame is exactly WIDTH bits, no parity logic.

Decomposition:
- Package psg_pkg: state enum (IDLE, SEND, GAP), FRAME_LEN constant (WIDTH or WIDTH+1 under macro), bit-index width $clog2(FRAME_LEN).
- Sub-module psg_piso: parallel-load, shift-left serializer with load/shift enables; top holds FSM and frame/gap counters.

Test Plan:
- Reset: rst low mid-SEND of 6'b101101 -> data_o, valid_o, busy_o, done_o all 0 asynchronously; no done_o after release.
- load 6'b110000, start repeat_i=1 gap_i=0 -> data_o 1,1,0,0,0,0 on 6 cycles starting 1 cycle after start, valid_o high 6 cycles, done_o pulse next cycle.
- load 6'b111111, repeat_i=3, gap_i=2 -> three 6-cycle frames separated by exactly 2 valid_o=0 cycles; total busy 22 cycles; looped into programmable_sequence_detector loaded 6'b111111 -> detect_o fires per frame.
- repeat_i=0 continuous 6'b100110, gap_i=0, stop_i at bit 3 of frame 4 -> frame 4 completes all 6 bits, done_o next cycle, no frame 5.
- load_i=1 with 6'b000111 and start_i=1 while busy -> ignored; stream and pattern unchanged.
- SEQ_GEN_PARITY_EN defined, 6'b110100 -> 7 valid bits 1,1,0,1,0,0,1.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared state type and frame-length helpers for programmable_sequence_generator.
// Defining SEQ_GEN_PARITY_EN appends one even-parity bit to every frame.
package psg_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } psg_state_e;

`ifdef SEQ_GEN_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    localparam int unsigned DEFAULT_WIDTH = 6;
    localparam int unsigned FRAME_LEN     = DEFAULT_WIDTH + PARITY_BITS;
    localparam int unsigned IDX_W         = $clog2(FRAME_LEN);

    function automatic int unsigned frame_len(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

    function automatic int unsigned frame_idx_w(input int unsigned width);
        return $clog2(width + PARITY_BITS);
    endfunction

endpackage

// File: rtl/psg_piso.sv
// Parallel-load, shift-left serializer; o_bit is the register MSB.
// Shifting fills with zeros, so the output idles low once a frame has drained.
module psg_piso #(
    parameter int unsigned W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_par,
    output logic         o_bit
);

    logic [W-1:0] r_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_par;
        end else if (i_shift) begin
            r_shift <= {r_shift[W-2:0], 1'b0};
        end
    end

    assign o_bit = r_shift[W-1];

endmodule

// File: rtl/programmable_sequence_generator.sv
// Serializes a programmable pattern MSB-first, repeated N times or continuously, with idle gaps.
// Optional SEQ_GEN_PARITY_EN appends an even-parity bit to each frame.
module programmable_sequence_generator
    import psg_pkg::*;
#(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned REPEAT_W = 4,
    parameter int unsigned GAP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [WIDTH-1:0]    prog_sequence_i,
    input  logic                start_i,
    input  logic [REPEAT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0]    gap_i,
    input  logic                stop_i,
    output logic                data_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned LEN   = frame_len(WIDTH);
    localparam int unsigned BIT_W = frame_idx_w(WIDTH);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(LEN - 1);

    psg_state_e          r_state, w_state_d;
    logic [WIDTH-1:0]    r_pattern, w_pattern_d;
    logic [BIT_W-1:0]    r_bit_idx, w_bit_idx_d;
    logic [REPEAT_W-1:0] r_frame_cnt, w_frame_cnt_d;
    logic [REPEAT_W-1:0] r_repeat, w_repeat_d;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt_d;
    logic [GAP_W-1:0]    r_gap, w_gap_d;
    logic                r_stop, w_stop_d;
    logic                r_valid, w_valid_d;
    logic                r_busy, w_busy_d;
    logic                r_done, w_done_d;
    logic                w_piso_load, w_piso_shift, w_begin_frame;
    logic                w_last_frame;
    logic [LEN-1:0]      w_frame_word;

`ifdef SEQ_GEN_PARITY_EN
    assign w_frame_word = {w_pattern_d, ^w_pattern_d};
`else
    assign w_frame_word = w_pattern_d;
`endif

    // A stop request seen on the final bit still ends the stream after this frame.
    assign w_last_frame = r_stop | stop_i | ((r_repeat != '0) && (r_frame_cnt == r_repeat));

    always_comb begin
        w_state_d     = r_state;
        w_pattern_d   = r_pattern;
        w_bit_idx_d   = r_bit_idx;
        w_frame_cnt_d = r_frame_cnt;
        w_repeat_d    = r_repeat;
        w_gap_cnt_d   = r_gap_cnt;
        w_gap_d       = r_gap;
        w_stop_d      = r_stop;
        w_valid_d     = 1'b0;
        w_busy_d      = 1'b0;
        w_done_d      = 1'b0;
        w_piso_load   = 1'b0;
        w_piso_shift  = 1'b0;
        w_begin_frame = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (load_i) begin
                    w_pattern_d = prog_sequence_i;
                end
                if (start_i) begin
                    w_repeat_d    = repeat_i;
                    w_gap_d       = gap_i;
                    w_stop_d      = 1'b0;
                    w_frame_cnt_d = REPEAT_W'(1);
                    w_begin_frame = 1'b1;
                end
            end
            StSend: begin
                w_stop_d = r_stop | stop_i;
                w_busy_d = 1'b1;
                if (r_bit_idx != '0) begin
                    w_bit_idx_d  = r_bit_idx - 1'b1;
                    w_piso_shift = 1'b1;
                    w_valid_d    = 1'b1;
                end else if (w_last_frame) begin
                    w_piso_shift = 1'b1;
                    w_busy_d     = 1'b0;
                    w_done_d     = 1'b1;
                    w_state_d    = StIdle;
                end else if (r_gap != '0) begin
                    w_piso_shift = 1'b1;
                    w_gap_cnt_d  = r_gap - 1'b1;
                    w_state_d    = StGap;
                end else begin
                    w_begin_frame = 1'b1;
                    if (r_repeat != '0) begin
                        w_frame_cnt_d = r_frame_cnt + 1'b1;
                    end
                end
            end
            StGap: begin
                w_busy_d = 1'b1;
                if (stop_i) begin
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = StIdle;
                end else if (r_gap_cnt == '0) begin
                    w_begin_frame = 1'b1;
                    if (r_repeat != '0) begin
                        w_frame_cnt_d = r_frame_cnt + 1'b1;
                    end
                end else begin
                    w_gap_cnt_d = r_gap_cnt - 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_begin_frame) begin
            w_bit_idx_d = LAST_IDX;
            w_piso_load = 1'b1;
            w_valid_d   = 1'b1;
            w_busy_d    = 1'b1;
            w_state_d   = StSend;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_pattern   <= '0;
            r_bit_idx   <= '0;
            r_frame_cnt <= '0;
            r_repeat    <= '0;
            r_gap_cnt   <= '0;
            r_gap       <= '0;
            r_stop      <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_pattern   <= w_pattern_d;
            r_bit_idx   <= w_bit_idx_d;
            r_frame_cnt <= w_frame_cnt_d;
            r_repeat    <= w_repeat_d;
            r_gap_cnt   <= w_gap_cnt_d;
            r_gap       <= w_gap_d;
            r_stop      <= w_stop_d;
            r_valid     <= w_valid_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
        end
    end

    psg_piso #(
        .W(LEN)
    ) u_piso (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_piso_load),
        .i_shift (w_piso_shift),
        .i_par   (w_frame_word),
        .o_bit   (data_o)
    );

    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_programmable_sequence_generator.sv
// Directed bench for programmable_sequence_generator (default parameters).
// Build with SEQ_GEN_PARITY_EN defined to exercise the parity-bit frame.
module tb_programmable_sequence_generator;

`ifdef SEQ_GEN_PARITY_EN
    localparam int LEN = 7;
`else
    localparam int LEN = 6;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_i = 1'b0;
    logic [5:0] prog_sequence_i = '0;
    logic       start_i = 1'b0;
    logic [3:0] repeat_i = '0;
    logic [3:0] gap_i = '0;
    logic       stop_i = 1'b0;
    logic       data_o, valid_o, busy_o, done_o;

    int n_checks = 0;
    int n_pass = 0;
    int busy_seen = 0;

    programmable_sequence_generator #(
        .WIDTH(6),
        .REPEAT_W(4),
        .GAP_W(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_i          (load_i),
        .prog_sequence_i (prog_sequence_i),
        .start_i         (start_i),
        .repeat_i        (repeat_i),
        .gap_i           (gap_i),
        .stop_i          (stop_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LEN-1:0] word_of(input logic [5:0] p);
`ifdef SEQ_GEN_PARITY_EN
        return {p, ^p};
`else
        return p;
`endif
    endfunction

    // Checks one whole frame starting at its first bit; stop_at = bit index to raise stop_i on.
    task automatic expect_frame(input logic [LEN-1:0] word, input int stop_at, input string tag);
        for (int b = LEN - 1; b >= 0; b--) begin
            check($sformatf("%s data b%0d", tag, b), {31'd0, data_o}, {31'd0, word[b]});
            check($sformatf("%s valid b%0d", tag, b), {31'd0, valid_o}, 32'd1);
            check($sformatf("%s busy b%0d", tag, b), {31'd0, busy_o}, 32'd1);
            if (busy_o) busy_seen++;
            if (b == stop_at) stop_i = 1'b1;
            tick();
            stop_i = 1'b0;
        end
    endtask

    task automatic expect_gap(input string tag);
        check({tag, " gap valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, " gap data"}, {31'd0, data_o}, 32'd0);
        check({tag, " gap busy"}, {31'd0, busy_o}, 32'd1);
        if (busy_o) busy_seen++;
        tick();
    endtask

    task automatic expect_done(input string tag);
        check({tag, " done"}, {31'd0, done_o}, 32'd1);
        check({tag, " done busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, " done valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, " done data"}, {31'd0, data_o}, 32'd0);
        tick();
        check({tag, " done pulse"}, {31'd0, done_o}, 32'd0);
        check({tag, " after valid"}, {31'd0, valid_o}, 32'd0);
    endtask

    task automatic begin_stream(input logic do_load, input logic [5:0] p, input logic [3:0] rep,
                                input logic [3:0] gap);
        load_i = do_load;
        prog_sequence_i = p;
        start_i = 1'b1;
        repeat_i = rep;
        gap_i = gap;
        tick();
        load_i = 1'b0;
        start_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst data", {31'd0, data_o}, 32'd0);
        check("rst valid", {31'd0, valid_o}, 32'd0);
        check("rst busy", {31'd0, busy_o}, 32'd0);
        check("rst done", {31'd0, done_o}, 32'd0);
        rst = 1'b1;
        tick();

        // Single frame, load and start together
        begin_stream(1'b1, 6'b110000, 4'd1, 4'd0);
        expect_frame(word_of(6'b110000), -1, "single");
        expect_done("single");

        // Three frames with two-cycle gaps
        load_i = 1'b1;
        prog_sequence_i = 6'b111111;
        tick();
        load_i = 1'b0;
        busy_seen = 0;
        begin_stream(1'b0, 6'b000000, 4'd3, 4'd2);
        expect_frame(word_of(6'b111111), -1, "rep3 f1");
        expect_gap("rep3 g1a");
        expect_gap("rep3 g1b");
        expect_frame(word_of(6'b111111), -1, "rep3 f2");
        expect_gap("rep3 g2a");
        expect_gap("rep3 g2b");
        expect_frame(word_of(6'b111111), -1, "rep3 f3");
        check("rep3 busy cycles", busy_seen, 3 * LEN + 4);
        expect_done("rep3");

        // Continuous, stop during bit 3 of frame 4
        begin_stream(1'b1, 6'b100110, 4'd0, 4'd0);
        expect_frame(word_of(6'b100110), -1, "cont f1");
        expect_frame(word_of(6'b100110), -1, "cont f2");
        expect_frame(word_of(6'b100110), -1, "cont f3");
        expect_frame(word_of(6'b100110), 3, "cont f4");
        expect_done("cont");

        // load/start/repeat/gap ignored while busy
        begin_stream(1'b1, 6'b110011, 4'd2, 4'd0);
        load_i = 1'b1;
        prog_sequence_i = 6'b000111;
        start_i = 1'b1;
        repeat_i = 4'd0;
        gap_i = 4'd3;
        expect_frame(word_of(6'b110011), -1, "busy f1");
        load_i = 1'b0;
        start_i = 1'b0;
        expect_frame(word_of(6'b110011), -1, "busy f2");
        expect_done("busy");

        // stop_i inside a gap ends the stream at once
        begin_stream(1'b1, 6'b101010, 4'd0, 4'd3);
        expect_frame(word_of(6'b101010), -1, "gstop f1");
        expect_gap("gstop g1");
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        expect_done("gstop");

`ifdef SEQ_GEN_PARITY_EN
        begin_stream(1'b1, 6'b110100, 4'd1, 4'd0);
        expect_frame(7'b1101001, -1, "parity");
        expect_done("parity");
`endif

        // Asynchronous reset mid-frame
        begin_stream(1'b1, 6'b101101, 4'd0, 4'd0);
        check("mid b5", {31'd0, data_o}, 32'd1);
        tick();
        check("mid b4", {31'd0, data_o}, 32'd0);
        rst = 1'b0;
        #1;
        check("arst valid", {31'd0, valid_o}, 32'd0);
        check("arst busy", {31'd0, busy_o}, 32'd0);
        check("arst done", {31'd0, done_o}, 32'd0);
        check("arst data", {31'd0, data_o}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post rst done", {31'd0, done_o}, 32'd0);
        check("post rst busy", {31'd0, busy_o}, 32'd0);
        tick();
        check("post rst done2", {31'd0, done_o}, 32'd0);
        // Pattern register was cleared by reset
        begin_stream(1'b0, 6'b000000, 4'd1, 4'd0);
        expect_frame(word_of(6'b000000), -1, "cleared");
        expect_done("cleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
